// File: rtl/oai22_chk_pkg.sv
// Shared types and golden function for the OAI22 exhaustive sweep checker.
package oai22_chk_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } state_t;

   localparam logic [3:0] VEC_LAST = 4'hF;

   // Bit positions of the cell inputs inside the sweep vector.
   localparam int unsigned A0_BIT = 3;
   localparam int unsigned A1_BIT = 2;
   localparam int unsigned B0_BIT = 1;
   localparam int unsigned B1_BIT = 0;

   function automatic logic oai22_ref(input logic [3:0] vec);
      return ~((vec[A0_BIT] | vec[A1_BIT]) & (vec[B0_BIT] | vec[B1_BIT]));
   endfunction

endpackage

// File: rtl/oai22_sweep_checker.sv
// Exhaustive OAI22 cell self-test: sweeps all 16 input vectors, compares Y against the
// golden function, and reports a saturating mismatch count plus the first failing vector.
module oai22_sweep_checker
   import oai22_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 5
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             Y,
   output logic             A0,
   output logic             A1,
   output logic             B0,
   output logic             B1,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic             FAIL_VALID,
   output logic [3:0]       FAIL_VEC
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..15");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

   state_t           r_state;
   logic [3:0]       r_vec;
   logic [3:0]       r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_err;
   logic             r_fail_valid;
   logic [3:0]       r_fail_vec;

   logic             w_mismatch;
   logic [CNT_W-1:0] w_err_next;

   always_comb begin
      w_mismatch = (Y != oai22_ref(r_vec));
      w_err_next = r_err;
      if (w_mismatch && (r_err != ERR_MAX)) begin
         w_err_next = r_err + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_state      <= StIdle;
         r_vec        <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (START) begin
                  r_state      <= StSettle;
                  r_vec        <= '0;
                  r_cnt        <= SETTLE_INIT;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
                  r_err        <= '0;
                  r_fail_valid <= 1'b0;
                  r_fail_vec   <= '0;
               end
            end
            StSettle: begin
               if (r_cnt == '0) begin
                  r_state <= StSample;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StSample: begin
               r_err <= w_err_next;
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_fail_vec   <= r_vec;
               end
               if (r_vec == VEC_LAST) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  // Judged on the saturated count including this last sample.
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_state <= StSettle;
                  r_vec   <= r_vec + 1'b1;
                  r_cnt   <= SETTLE_INIT;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign A0         = r_vec[A0_BIT];
   assign A1         = r_vec[A1_BIT];
   assign B0         = r_vec[B0_BIT];
   assign B1         = r_vec[B1_BIT];
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign PASS       = r_pass;
   assign ERR_CNT    = r_err;
   assign FAIL_VALID = r_fail_valid;
   assign FAIL_VEC   = r_fail_vec;

endmodule

// File: tb/tb_oai22_sweep_checker.sv
// Bench for oai22_sweep_checker: three instances (settle 2/cnt 5, settle 2/cnt 3,
// settle 1/cnt 5) driven by table-based cell models, checked against a sweep-level model.
module tb_oai22_sweep_checker;

   logic       clk;
   logic [2:0] rn;
   logic [2:0] start;
   logic [15:0] resp [3];

   wire [2:0] y, a0, a1, b0, b1, busy, done, pass, fv;
   wire [3:0] fvec0, fvec1, fvec2;
   wire [4:0] err0, err2;
   wire [2:0] err1;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] good_tbl;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign y[0] = resp[0][{a0[0], a1[0], b0[0], b1[0]}];
   assign y[1] = resp[1][{a0[1], a1[1], b0[1], b1[1]}];
   assign y[2] = resp[2][{a0[2], a1[2], b0[2], b1[2]}];

   oai22_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(5)) u_dut0 (
      .CLK(clk), .RN(rn[0]), .START(start[0]), .Y(y[0]),
      .A0(a0[0]), .A1(a1[0]), .B0(b0[0]), .B1(b1[0]),
      .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_CNT(err0),
      .FAIL_VALID(fv[0]), .FAIL_VEC(fvec0)
   );

   oai22_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(3)) u_dut1 (
      .CLK(clk), .RN(rn[1]), .START(start[1]), .Y(y[1]),
      .A0(a0[1]), .A1(a1[1]), .B0(b0[1]), .B1(b1[1]),
      .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_CNT(err1),
      .FAIL_VALID(fv[1]), .FAIL_VEC(fvec1)
   );

   oai22_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(5)) u_dut2 (
      .CLK(clk), .RN(rn[2]), .START(start[2]), .Y(y[2]),
      .A0(a0[2]), .A1(a1[2]), .B0(b0[2]), .B1(b1[2]),
      .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_CNT(err2),
      .FAIL_VALID(fv[2]), .FAIL_VEC(fvec2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int settle_of(input int k);
      return (k == 2) ? 1 : 2;
   endfunction

   function automatic int err_max_of(input int k);
      return (k == 1) ? 7 : 31;
   endfunction

   function automatic logic [3:0] vec_of(input int k);
      return {a0[k], a1[k], b0[k], b1[k]};
   endfunction

   function automatic logic [4:0] err_of(input int k);
      case (k)
         0:       return err0;
         1:       return {2'b00, err1};
         default: return err2;
      endcase
   endfunction

   function automatic logic [3:0] fvec_of(input int k);
      case (k)
         0:       return fvec0;
         1:       return fvec1;
         default: return fvec2;
      endcase
   endfunction

   // Golden OAI22 from the cell's truth: output low only when both OR pairs are true.
   function automatic logic golden(input int v);
      int a_any;
      int b_any;
      a_any = ((v / 8) % 2) + ((v / 4) % 2);
      b_any = ((v / 2) % 2) + (v % 2);
      return (a_any > 0 && b_any > 0) ? 1'b0 : 1'b1;
   endfunction

   task automatic check_reset_state(input int k, input string tag);
      check({tag, "_busy"}, 32'(busy[k]), 0);
      check({tag, "_done"}, 32'(done[k]), 0);
      check({tag, "_pass"}, 32'(pass[k]), 0);
      check({tag, "_err"}, 32'(err_of(k)), 0);
      check({tag, "_fv"}, 32'(fv[k]), 0);
      check({tag, "_fvec"}, 32'(fvec_of(k)), 0);
      check({tag, "_vec"}, 32'(vec_of(k)), 0);
   endtask

   // Steps until DONE, checking each vector's hold time; returns cycles after acceptance.
   task automatic run_to_done(input int k, input bit inject, output int cycles);
      logic [3:0] prev;
      int hold;
      bit f3, f10;
      cycles = 0;
      prev = vec_of(k);
      hold = 1;
      f3 = 0;
      f10 = 0;
      while (!done[k] && cycles < 200) begin
         start[k] = 1'b0;
         if (inject && vec_of(k) == 4'd3 && !f3) begin
            start[k] = 1'b1;
            f3 = 1;
         end
         if (inject && vec_of(k) == 4'd10 && !f10) begin
            start[k] = 1'b1;
            f10 = 1;
         end
         tick();
         cycles++;
         if (vec_of(k) == prev) begin
            hold++;
         end else begin
            check($sformatf("hold_k%0d_v%0d", k, prev), 32'(hold), 32'(settle_of(k) + 1));
            prev = vec_of(k);
            hold = 1;
         end
      end
      start[k] = 1'b0;
   endtask

   task automatic sweep(input int k, input logic [15:0] tbl, input bit inject);
      int errs;
      int first;
      int exp_err;
      int cycles;
      errs = 0;
      first = -1;
      for (int v = 0; v < 16; v++) begin
         if (tbl[v] != golden(v)) begin
            errs++;
            if (first < 0) first = v;
         end
      end
      exp_err = (errs > err_max_of(k)) ? err_max_of(k) : errs;

      resp[k] = tbl;
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      check("busy_on_start", 32'(busy[k]), 1);
      check("done_clear_on_start", 32'(done[k]), 0);
      run_to_done(k, inject, cycles);
      check($sformatf("latency_k%0d", k), 32'(cycles), 32'(16 * (settle_of(k) + 1)));
      check("busy_at_end", 32'(busy[k]), 0);
      check("pass", 32'(pass[k]), 32'(exp_err == 0));
      check("err_cnt", 32'(err_of(k)), 32'(exp_err));
      check("fail_valid", 32'(fv[k]), 32'(first >= 0));
      check("fail_vec", 32'(fvec_of(k)), (first >= 0) ? 32'(first) : 32'd0);
      check("vec_final", 32'(vec_of(k)), 32'hF);
   endtask

   initial begin
      int cycles;
      int guard;
      logic [15:0] rt;

      for (int v = 0; v < 16; v++) good_tbl[v] = golden(v);
      for (int k = 0; k < 3; k++) resp[k] = good_tbl;
      rn = 3'b000;
      start = 3'b000;
      tick();
      tick();
      for (int k = 0; k < 3; k++) check_reset_state(k, $sformatf("reset_k%0d", k));
      rn = 3'b111;
      tick();

      sweep(0, good_tbl, 0);
      check("good_vec_1111", 32'(vec_of(0)), 32'hF);
      sweep(0, 16'hFFFF, 0);
      check("sa1_err_9", 32'(err0), 9);
      check("sa1_fvec_0101", 32'(fvec0), 5);
      sweep(0, 16'h0000, 0);
      sweep(1, 16'h0000, 0);
      check("sa0_cnt3_err_7", 32'(err1), 7);
      sweep(1, 16'hFFFF, 0);
      check("sa1_cnt3_saturates", 32'(err1), 7);
      sweep(2, good_tbl, 0);
      sweep(2, 16'hFFFF, 0);

      // START pulses mid-sweep must not restart or stretch the sweep.
      sweep(0, good_tbl, 1);

      // START in DONE restarts on that very edge.
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      check("restart_done", 32'(done[0]), 0);
      check("restart_pass", 32'(pass[0]), 0);
      check("restart_busy", 32'(busy[0]), 1);
      check("restart_vec", 32'(vec_of(0)), 0);
      run_to_done(0, 0, cycles);
      check("restart_latency", 32'(cycles), 48);
      check("restart_pass_end", 32'(pass[0]), 1);

      // Reset in the middle of vector 6's settle window.
      resp[0] = 16'hFFFF;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      guard = 0;
      while (vec_of(0) != 4'd6 && guard < 200) begin
         tick();
         guard++;
      end
      check("reach_vec6", 32'(vec_of(0)), 6);
      check("err_before_rst", 32'(err0), 1);
      rn[0] = 1'b0;
      tick();
      rn[0] = 1'b1;
      check_reset_state(0, "midrst");
      tick();
      check("idle_stays_idle", 32'(busy[0]), 0);
      sweep(0, good_tbl, 0);

      // Reset beats a simultaneous START.
      rn[0] = 1'b0;
      start[0] = 1'b1;
      tick();
      rn[0] = 1'b1;
      start[0] = 1'b0;
      check_reset_state(0, "rst_wins");

      for (int i = 0; i < 9; i++) begin
         rt = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rt = good_tbl;
         sweep(i % 3, rt, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
